compute_work_pipe: RTL

Parametrised, multi-channel successor of the single-channel compute/work logic. Up to NUM_CH requesters each present an operand pair and an opcode over valid/ready. A round-robin arbiter grants one channel per cycle into a 2-stage pipeline. The pipeline returns a WIDTH+1-bit result tagged with its source channel over a back-pressured valid/ready output port. The block sits between per-channel operand registers and a shared result consumer.

---
 rtl/compute_work_pipe_pkg.sv | 41 ++++
 rtl/compute_work_pipe_rr_arbiter.sv | 42 ++++
 rtl/compute_work_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/compute_work_pipe_pkg.sv
// Shared opcode type and the reference result function for the compute/work pipe.
// Operands are carried at the maximum width and trimmed to the live width inside compute().
package compute_work_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_WORK = 2'd1,
    OP_SUB  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] msb_mask(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic logic [MAX_W:0] compute(input op_t op, input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b, input int width);
    logic [MAX_W-1:0] keep;
    logic [MAX_W-1:0] a_k;
    logic [MAX_W-1:0] b_k;
    logic [MAX_W:0]   res;
    keep = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    a_k  = a & keep;
    b_k  = b & keep;
    res  = '0;
    case (op)
      OP_ADD:  res = {1'b0, a_k} + {1'b0, b_k};
      OP_WORK: res = {1'b0, (a_k | msb_mask(width)) & ~b_k & keep};
      OP_SUB: begin
        res        = {1'b0, (a_k - b_k) & keep};
        res[width] = (a_k < b_k);
      end
      OP_PASS: res = {1'b0, a_k};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/compute_work_pipe_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (mod N) for the first requester.
// ptr moves past the granted channel only when the grant is actually taken.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    logic found;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/compute_work_pipe.sv
// Multi-channel compute/work pipe: round-robin intake, two register stages,
// back-pressured result port. A single global enable freezes everything on stall.
module compute_work_pipe
  import compute_work_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  input  logic [NUM_CH*WIDTH-1:0] in_a_i,
  input  logic [NUM_CH*WIDTH-1:0] in_b_i,
  input  logic [NUM_CH*2-1:0]     in_op_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH:0]          out_data_o,
  output logic [CH_W-1:0]         out_chan_o
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              stall;
  logic              xfer;
  logic [WIDTH-1:0]  g_a;
  logic [WIDTH-1:0]  g_b;
  logic [1:0]        g_op;

  logic              v1;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  op_t               s1_op;
  logic [CH_W-1:0]   s1_ch;
  logic              v2;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (in_valid_i),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready depends only on grant and stall, never on operand data.
  assign stall       = v2 & ~out_ready_i;
  assign in_ready_o  = (rst_i || stall) ? '0 : grant;
  assign xfer        = |(in_valid_i & in_ready_o);
  assign out_valid_o = v2;

  always_comb begin
    g_a  = '0;
    g_b  = '0;
    g_op = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        g_a  = in_a_i[c*WIDTH +: WIDTH];
        g_b  = in_b_i[c*WIDTH +: WIDTH];
        g_op = in_op_i[c*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1         <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_ch      <= '0;
      v2         <= 1'b0;
      out_data_o <= '0;
      out_chan_o <= '0;
    end else if (!stall) begin
      v1 <= xfer;
      if (xfer) begin
        s1_a  <= g_a;
        s1_b  <= g_b;
        s1_op <= op_t'(g_op);
        s1_ch <= grant_idx;
      end
      v2 <= v1;
      // Result registers only load real transactions so idle output stays put.
      if (v1) begin
        out_data_o <= (WIDTH+1)'(compute(s1_op, MAX_W'(s1_a), MAX_W'(s1_b), WIDTH));
        out_chan_o <= s1_ch;
      end
    end
  end

endmodule
